// File: rtl/forwarding_scoreboard.sv
// Decode-stage operand forwarding and hazard unit: a shift-register scoreboard of in-flight
// register writes selects the youngest producer per source port and flags not-yet-ready results.
module forwarding_scoreboard #(
    parameter int unsigned NREAD   = 2,
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned REGBITS = 5,
    parameter int unsigned SELW    = $clog2(DEPTH + 1),
    // A single tracked stage still needs a 1-bit ready field.
    parameter int unsigned RDYW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREAD*REGBITS-1:0] rs_dec,
    input  logic                     issue_valid,
    input  logic                     issue_wen,
    input  logic [REGBITS-1:0]       issue_rd,
    input  logic [RDYW-1:0]          issue_rdy,
    input  logic                     freeze,
    input  logic                     flush,
    output logic [NREAD*SELW-1:0]    fwd_sel,
    output logic                     hazard_stall,
    output logic [31:0]              stall_cycles
);

    logic [DEPTH-1:0]   slot_valid;
    logic [REGBITS-1:0] slot_rd  [DEPTH];
    logic [RDYW-1:0]    slot_rdy [DEPTH];
    logic [NREAD-1:0]   port_stall;
    logic               load_slot0;

    // Scan oldest to youngest so the youngest matching slot has the final word.
    always_comb begin
        fwd_sel    = '0;
        port_stall = '0;
        for (int p = 0; p < int'(NREAD); p++) begin
            for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
                if (slot_valid[i] && (slot_rd[i] == rs_dec[p*REGBITS +: REGBITS]) &&
                    (rs_dec[p*REGBITS +: REGBITS] != '0)) begin
                    if (int'(slot_rdy[i]) <= i) begin
                        fwd_sel[p*SELW +: SELW] = SELW'(i + 1);
                        port_stall[p]           = 1'b0;
                    end else begin
                        fwd_sel[p*SELW +: SELW] = '0;
                        port_stall[p]           = 1'b1;
                    end
                end
            end
        end
    end

    assign hazard_stall = issue_valid & (|port_stall);
    assign load_slot0   = issue_valid & issue_wen & (issue_rd != '0) & ~hazard_stall & ~flush;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            slot_valid <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                slot_rd[i]  <= '0;
                slot_rdy[i] <= '0;
            end
        end else if (freeze) begin
            if (flush) begin
                slot_valid[0] <= 1'b0;
            end
        end else begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                slot_valid[i] <= slot_valid[i-1];
                slot_rd[i]    <= slot_rd[i-1];
                slot_rdy[i]   <= slot_rdy[i-1];
            end
            slot_valid[0] <= load_slot0;
            slot_rd[0]    <= issue_rd;
            slot_rdy[0]   <= issue_rdy;
        end
    end

    // Only hazard stalls are counted; cycles lost to freeze belong to the memory system.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cycles <= '0;
        end else if (hazard_stall && !freeze && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard: a driver queues hand-computed expectations per cycle
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_forwarding_scoreboard;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [9:0]  rs_dec = '0;
    logic        issue_valid = 1'b0;
    logic        issue_wen = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic [1:0]  issue_rdy = '0;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  fwd_sel;
    logic        hazard_stall;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  fwd;
        logic        stall;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    forwarding_scoreboard dut (
        .CLK          (CLK),
        .RST          (RST),
        .rs_dec       (rs_dec),
        .issue_valid  (issue_valid),
        .issue_wen    (issue_wen),
        .issue_rd     (issue_rd),
        .issue_rdy    (issue_rdy),
        .freeze       (freeze),
        .flush        (flush),
        .fwd_sel      (fwd_sel),
        .hazard_stall (hazard_stall),
        .stall_cycles (stall_cycles)
    );

    always #5 CLK = ~CLK;

    // Inputs for one cycle plus the outputs expected during that cycle.
    task automatic step(input logic [4:0] r0, input logic [4:0] r1, input logic iv,
                        input logic wen, input logic [4:0] rd, input logic [1:0] rdy,
                        input logic frz, input logic fl, input logic rs,
                        input logic [1:0] e0, input logic [1:0] e1, input logic es,
                        input logic [31:0] ec, input string nm);
        exp_t e;
        @(posedge CLK);
        #1;
        RST         = rs;
        rs_dec      = {r1, r0};
        issue_valid = iv;
        issue_wen   = wen;
        issue_rd    = rd;
        issue_rdy   = rdy;
        freeze      = frz;
        flush       = fl;
        e.fwd   = {e1, e0};
        e.stall = es;
        e.cnt   = ec;
        e.name  = nm;
        exp_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (fwd_sel !== e.fwd) begin
                errors++;
                $display("FAIL %s fwd_sel got %h want %h", e.name, fwd_sel, e.fwd);
            end
            checks++;
            if (hazard_stall !== e.stall) begin
                errors++;
                $display("FAIL %s hazard_stall got %b want %b", e.name, hazard_stall, e.stall);
            end
            checks++;
            if (stall_cycles !== e.cnt) begin
                errors++;
                $display("FAIL %s stall_cycles got %0d want %0d", e.name, stall_cycles, e.cnt);
            end
        end
    end

    initial begin
        repeat (2) @(posedge CLK);
        //    r0  r1  iv wen rd  rdy frz fl rst  e0 e1 st cnt
        step(0,  0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, "reset_idle");
        // ALU chain
        step(0,  0,  1, 1, 5,  0,  0, 0, 0,  0, 0, 0, 0, "alu_issue");
        step(5,  5,  1, 0, 0,  0,  0, 0, 0,  1, 1, 0, 0, "alu_ex");
        step(5,  5,  1, 0, 0,  0,  0, 0, 0,  2, 2, 0, 0, "alu_mem");
        step(5,  5,  1, 0, 0,  0,  0, 0, 0,  3, 3, 0, 0, "alu_wb");
        step(5,  5,  1, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, "alu_dropped");
        // Load-use: stalled consumer also writes r9, which must not enter until it proceeds
        step(0,  0,  1, 1, 8,  1,  0, 0, 0,  0, 0, 0, 0, "load_issue");
        step(8,  0,  1, 1, 9,  0,  0, 0, 0,  0, 0, 1, 0, "load_use_stall");
        step(8,  0,  1, 1, 9,  0,  0, 0, 0,  2, 0, 0, 1, "load_use_fwd");
        step(9,  8,  1, 0, 0,  0,  0, 0, 0,  1, 3, 0, 1, "mixed_slots");
        // Youngest wins, r0 never forwarded
        step(0,  0,  1, 1, 3,  0,  0, 0, 0,  0, 0, 0, 1, "r3_first");
        step(3,  3,  1, 1, 3,  0,  0, 0, 0,  1, 1, 0, 1, "r3_second");
        step(3,  0,  1, 1, 0,  0,  0, 0, 0,  1, 0, 0, 1, "youngest_wins");
        step(0,  3,  1, 0, 0,  0,  0, 0, 0,  0, 2, 0, 1, "r0_not_tracked");
        step(0,  0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 1, "idle");
        // Stall gated by issue_valid
        step(0,  0,  1, 1, 7,  1,  0, 0, 0,  0, 0, 0, 1, "load7_issue");
        step(7,  0,  0, 0, 0,  0,  0, 0, 0,  0, 0, 0, 1, "stall_gated");
        step(7,  7,  1, 0, 0,  0,  0, 0, 0,  2, 2, 0, 1, "load7_fwd");
        // Freeze holds slots and counter
        step(0,  0,  1, 1, 4,  1,  0, 0, 0,  0, 0, 0, 1, "load4_issue");
        step(4,  0,  1, 0, 0,  0,  1, 0, 0,  0, 0, 1, 1, "freeze_1");
        step(4,  0,  1, 0, 0,  0,  1, 0, 0,  0, 0, 1, 1, "freeze_2");
        step(4,  0,  1, 0, 0,  0,  1, 0, 0,  0, 0, 1, 1, "freeze_3");
        step(4,  0,  1, 0, 0,  0,  0, 0, 0,  0, 0, 1, 1, "unfreeze_stall");
        step(4,  0,  1, 0, 0,  0,  0, 0, 0,  2, 0, 0, 2, "unfreeze_fwd");
        // Flush
        step(0,  0,  1, 1, 6,  0,  0, 1, 0,  0, 0, 0, 2, "flush_issue");
        step(6,  4,  1, 0, 0,  0,  0, 0, 0,  0, 0, 0, 2, "flushed_r6");
        // Freeze with flush clears slot 0 only
        step(0,  0,  1, 1, 10, 0,  0, 0, 0,  0, 0, 0, 2, "r10_issue");
        step(10, 0,  1, 1, 11, 0,  0, 0, 0,  1, 0, 0, 2, "r11_issue");
        step(11, 10, 1, 1, 12, 0,  1, 1, 0,  1, 2, 0, 2, "freeze_flush");
        step(11, 10, 1, 0, 0,  0,  0, 0, 0,  0, 2, 0, 2, "after_freeze_flush");
        // Asynchronous reset with populated slots and nonzero counter
        step(0,  0,  1, 1, 13, 1,  0, 0, 0,  0, 0, 0, 2, "r13_issue");
        step(13, 0,  1, 0, 0,  0,  0, 0, 0,  0, 0, 1, 2, "r13_stall");
        step(13, 13, 1, 0, 0,  0,  0, 0, 0,  2, 2, 0, 3, "r13_fwd");
        step(13, 13, 1, 0, 0,  0,  0, 0, 1,  0, 0, 0, 0, "async_reset");
        step(13, 13, 1, 0, 0,  0,  0, 0, 0,  0, 0, 0, 0, "post_reset");
        repeat (4) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
